// File: rtl/bus_err_injector_pkg.sv
// Shared types and constants for the bus response error injector.
package bus_err_injector_pkg;

    typedef logic [15:0] cnt_t;

    localparam cnt_t CntMax = 16'hFFFF;

    localparam int unsigned CfgAddrWidth = 48;
    localparam int unsigned CfgErrBits   = 3;

    // Reserved for a future register wrapper that drives the cfg_* ports.
    typedef struct packed {
        logic [CfgAddrWidth-1:0] addr_base;
        logic [CfgAddrWidth-1:0] addr_mask;
        logic [CfgErrBits-1:0]   err_code;
        cnt_t                    count;
    } cfg_t;

    typedef enum logic [1:0] {
        DISARMED,
        ARMED_LIMITED,
        ARMED_UNLIMITED
    } arm_state_e;

    function automatic cnt_t sat_inc(input cnt_t value);
        return (value == CntMax) ? value : value + cnt_t'(1);
    endfunction

endpackage

// File: rtl/bus_err_inj_tag_fifo.sv
// 1-bit tag FIFO with synchronous active-high reset; one per channel.
module bus_err_inj_tag_fifo #(
    parameter int unsigned Depth = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic tag,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Depth-1:0] mem;
    logic [PtrW:0]    wr_ptr;
    logic [PtrW:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                   (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
    assign head  = mem[rd_ptr[PtrW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted then and occupancy stays unchanged.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[PtrW-1:0]] <= tag;
                wr_ptr                <= wr_ptr + (PtrW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PtrW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/bus_err_injector.sv
// Tags address-matching requests and overrides the error code on the
// responses that belong to them.
module bus_err_injector
    import bus_err_injector_pkg::*;
#(
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned ErrBits        = 3,
    parameter int unsigned NumOutstanding = 4,
    parameter int unsigned NumChannels    = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumChannels-1:0] req_hs_valid_i,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [NumChannels-1:0] rsp_hs_valid_i,
    input  logic [NumChannels-1:0] rsp_burst_last_i,
    input  logic [ErrBits-1:0]     rsp_err_i,
    output logic [ErrBits-1:0]     rsp_err_o,
    input  logic [AddrWidth-1:0]   cfg_addr_base_i,
    input  logic [AddrWidth-1:0]   cfg_addr_mask_i,
    input  logic [ErrBits-1:0]     cfg_err_code_i,
    input  logic [15:0]            cfg_count_i,
    input  logic                   cfg_arm_i,
    input  logic                   cfg_disarm_i,
    output logic                   armed_o,
    output logic [15:0]            inj_count_o,
    output logic                   desync_o
);

    arm_state_e state, state_n;
    cnt_t       budget, budget_n;
    cnt_t       inj_count, inj_count_n;
    logic       desync, desync_n;

    logic                   armed;
    logic                   hit;
    logic                   req_any;
    logic                   arm_eff;
    logic [NumChannels-1:0] fifo_head;
    logic [NumChannels-1:0] fifo_full;
    logic [NumChannels-1:0] fifo_empty;
    logic [NumChannels-1:0] last_beat;
    logic [NumChannels-1:0] pop_valid;
    logic                   overflow;
    logic                   underflow;
    logic                   inj_inc;

    assign armed   = (state != DISARMED);
    assign hit     = armed &&
                     ((req_addr_i & cfg_addr_mask_i) == (cfg_addr_base_i & cfg_addr_mask_i));
    assign req_any = |req_hs_valid_i;
    assign arm_eff = cfg_arm_i & ~cfg_disarm_i;

    assign last_beat = rsp_hs_valid_i & rsp_burst_last_i;
    assign pop_valid = last_beat & ~fifo_empty;
    assign underflow = |(last_beat & fifo_empty);
    assign overflow  = |(req_hs_valid_i & fifo_full & ~pop_valid);
    assign inj_inc   = |(pop_valid & fifo_head);

    for (genvar g = 0; g < NumChannels; g++) begin : g_fifo
        bus_err_inj_tag_fifo #(
            .Depth(NumOutstanding)
        ) u_fifo (
            .clk  (clk_i),
            .rst  (rst_i),
            .push (req_hs_valid_i[g]),
            .pop  (last_beat[g]),
            .tag  (hit),
            .head (fifo_head[g]),
            .full (fifo_full[g]),
            .empty(fifo_empty[g])
        );
    end

    always_comb begin
        rsp_err_o = rsp_err_i;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            if (rsp_hs_valid_i[c] && !fifo_empty[c] && fifo_head[c]) begin
                rsp_err_o = cfg_err_code_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= DISARMED;
            budget    <= '0;
            inj_count <= '0;
            desync    <= 1'b0;
        end else begin
            state     <= state_n;
            budget    <= budget_n;
            inj_count <= inj_count_n;
            desync    <= desync_n;
        end
    end

    // Later assignments take priority: desync errors over budget
    // exhaustion, then disarm over arm.
    always_comb begin
        state_n     = state;
        budget_n    = budget;
        inj_count_n = inj_count;
        desync_n    = desync;

        if (req_any && hit && state == ARMED_LIMITED) begin
            budget_n = budget - cnt_t'(1);
            if (budget == cnt_t'(1)) begin
                state_n = DISARMED;
            end
        end

        if (inj_inc) begin
            inj_count_n = sat_inc(inj_count);
        end

        if (overflow || underflow) begin
            state_n  = DISARMED;
            desync_n = 1'b1;
        end

        if (cfg_disarm_i) begin
            state_n = DISARMED;
        end else if (arm_eff) begin
            budget_n    = cfg_count_i;
            state_n     = (cfg_count_i == '0) ? ARMED_UNLIMITED : ARMED_LIMITED;
            inj_count_n = '0;
            desync_n    = 1'b0;
        end
    end

    assign armed_o     = armed;
    assign inj_count_o = inj_count;
    assign desync_o    = desync;

    a_req_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_hs_valid_i));
    a_rsp_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(rsp_hs_valid_i));
    a_arm_pulse : assert property (@(posedge clk_i) disable iff (rst_i)
        cfg_arm_i |=> !cfg_arm_i);

endmodule

// File: tb/tb_bus_err_injector.sv
// Self-checking bench for bus_err_injector: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_bus_err_injector;

    localparam int AW = 48;
    localparam int EB = 3;
    localparam int NO = 4;
    localparam int NC = 2;

    localparam logic [AW-1:0] Base = 48'h0000_0000_1000;
    localparam logic [AW-1:0] Mask = 48'hFFFF_FFFF_F000;
    localparam logic [EB-1:0] Code = 3'b010;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [NC-1:0] req_hs_valid_i;
    logic [AW-1:0] req_addr_i;
    logic [NC-1:0] rsp_hs_valid_i;
    logic [NC-1:0] rsp_burst_last_i;
    logic [EB-1:0] rsp_err_i;
    logic [EB-1:0] rsp_err_o;
    logic [AW-1:0] cfg_addr_base_i;
    logic [AW-1:0] cfg_addr_mask_i;
    logic [EB-1:0] cfg_err_code_i;
    logic [15:0]   cfg_count_i;
    logic          cfg_arm_i;
    logic          cfg_disarm_i;
    logic          armed_o;
    logic [15:0]   inj_count_o;
    logic          desync_o;

    always #5 clk = ~clk;

    bus_err_injector #(
        .AddrWidth     (AW),
        .ErrBits       (EB),
        .NumOutstanding(NO),
        .NumChannels   (NC)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .req_hs_valid_i  (req_hs_valid_i),
        .req_addr_i      (req_addr_i),
        .rsp_hs_valid_i  (rsp_hs_valid_i),
        .rsp_burst_last_i(rsp_burst_last_i),
        .rsp_err_i       (rsp_err_i),
        .rsp_err_o       (rsp_err_o),
        .cfg_addr_base_i (cfg_addr_base_i),
        .cfg_addr_mask_i (cfg_addr_mask_i),
        .cfg_err_code_i  (cfg_err_code_i),
        .cfg_count_i     (cfg_count_i),
        .cfg_arm_i       (cfg_arm_i),
        .cfg_disarm_i    (cfg_disarm_i),
        .armed_o         (armed_o),
        .inj_count_o     (inj_count_o),
        .desync_o        (desync_o)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: per-channel queues of tags plus the armed/budget view.
    bit q0[$];
    bit q1[$];
    bit m_armed;
    bit m_unlim;
    int m_budget;
    int m_cnt;
    bit m_desync;

    logic [EB-1:0] got_err;
    logic [EB-1:0] exp_err;

    function automatic void check(input string name, input logic [47:0] got,
                                  input logic [47:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic int qsize(input int c);
        return (c == 0) ? q0.size() : q1.size();
    endfunction

    function automatic bit qhead(input int c);
        return (c == 0) ? q0[0] : q1[0];
    endfunction

    function automatic bit qpop(input int c);
        if (c == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void qpush(input int c, input bit t);
        if (c == 0) q0.push_back(t);
        else        q1.push_back(t);
    endfunction

    function automatic logic [EB-1:0] model_err(input logic [NC-1:0] rsp,
                                                 input logic [EB-1:0] err);
        logic [EB-1:0] e = err;
        for (int c = 0; c < NC; c++)
            if (rsp[c] && qsize(c) > 0 && qhead(c)) e = cfg_err_code_i;
        return e;
    endfunction

    function automatic void model_step(input logic rst, input logic [NC-1:0] req,
                                       input logic [AW-1:0] addr, input logic [NC-1:0] rsp,
                                       input logic [NC-1:0] last, input logic arm,
                                       input logic disarm, input logic [15:0] count);
        bit hit, over, under, t;
        if (rst) begin
            q0.delete(); q1.delete();
            m_armed = 0; m_unlim = 0; m_budget = 0; m_cnt = 0; m_desync = 0;
            return;
        end
        hit   = m_armed && ((addr & cfg_addr_mask_i) == (cfg_addr_base_i & cfg_addr_mask_i));
        over  = 0;
        under = 0;
        for (int c = 0; c < NC; c++) begin
            if (rsp[c] && last[c]) begin
                if (qsize(c) == 0) under = 1;
                else begin
                    t = qpop(c);
                    if (t && m_cnt < 65535) m_cnt++;
                end
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (req[c]) begin
                if (qsize(c) >= NO) over = 1;
                else qpush(c, hit);
            end
        end
        if (hit && req != 0 && !m_unlim) begin
            m_budget--;
            if (m_budget == 0) m_armed = 0;
        end
        if (over || under) begin
            m_armed  = 0;
            m_desync = 1;
        end
        if (disarm) m_armed = 0;
        else if (arm) begin
            m_budget = count;
            m_unlim  = (count == 0);
            m_armed  = 1;
            m_cnt    = 0;
            m_desync = 0;
        end
    endfunction

    // One clock: drive, sample the combinational output mid-cycle, clock,
    // advance the model, and leave time 1 unit after the edge.
    task automatic drive(input logic rst, input logic [NC-1:0] req, input logic [AW-1:0] addr,
                         input logic [NC-1:0] rsp, input logic [NC-1:0] last,
                         input logic [EB-1:0] err, input logic arm, input logic disarm,
                         input logic [15:0] count);
        rst_i            = rst;
        req_hs_valid_i   = req;
        req_addr_i       = addr;
        rsp_hs_valid_i   = rsp;
        rsp_burst_last_i = last;
        rsp_err_i        = err;
        cfg_arm_i        = arm;
        cfg_disarm_i     = disarm;
        cfg_count_i      = count;
        #3;
        got_err = rsp_err_o;
        exp_err = model_err(rsp, err);
        @(posedge clk);
        model_step(rst, req, addr, rsp, last, arm, disarm, count);
        #1;
    endtask

    task automatic idle();
        drive(0, '0, '0, '0, '0, '0, 0, 0, '0);
    endtask

    task automatic arm(input logic [15:0] count);
        drive(0, '0, '0, '0, '0, '0, 1, 0, count);
    endtask

    task automatic req(input int ch, input logic [AW-1:0] addr);
        drive(0, NC'(1 << ch), addr, '0, '0, '0, 0, 0, '0);
    endtask

    task automatic beat(input int ch, input logic last, input logic [EB-1:0] err);
        drive(0, '0, '0, NC'(1 << ch), last ? NC'(1 << ch) : '0, err, 0, 0, '0);
    endtask

    typedef struct {
        logic [NC-1:0] req;
        logic [AW-1:0] addr;
        logic [NC-1:0] rsp;
        logic [NC-1:0] last;
        logic [EB-1:0] err;
        logic          arm;
        logic [15:0]   count;
        logic [EB-1:0] e_err;
        logic          e_armed;
        logic [15:0]   e_cnt;
        logic          e_desync;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [NC-1:0] r_req, r_rsp, r_last;
        logic [AW-1:0] r_addr;
        logic          r_arm, r_dis, prev_arm;
        int            rch, pch;

        cfg_addr_base_i = Base;
        cfg_addr_mask_i = Mask;
        cfg_err_code_i  = Code;
        rst_i = 1; req_hs_valid_i = '0; req_addr_i = '0; rsp_hs_valid_i = '0;
        rsp_burst_last_i = '0; rsp_err_i = '0; cfg_count_i = '0;
        cfg_arm_i = 0; cfg_disarm_i = 0;
        @(posedge clk); #1;

        // Reset values; a non-last beat on an empty FIFO passes through.
        drive(1, '0, '0, 2'b01, 2'b00, 3'b101, 0, 0, '0);
        check("reset_err_passthru", 48'(got_err), 48'h5);
        check("reset_armed", 48'(armed_o), 48'h0);
        check("reset_inj_count", 48'(inj_count_o), 48'h0);
        check("reset_desync", 48'(desync_o), 48'h0);

        // Budget of 2 on channel 0, then two-channel interleave with unlimited budget.
        tbl.push_back('{2'b00, 48'h0,    2'b00, 2'b00, 3'b000, 1, 16'd2, 3'b000, 1, 16'd0, 0});
        tbl.push_back('{2'b01, 48'h1004, 2'b00, 2'b00, 3'b000, 0, 16'd0, 3'b000, 1, 16'd0, 0});
        tbl.push_back('{2'b00, 48'h0,    2'b01, 2'b01, 3'b000, 0, 16'd0, 3'b010, 1, 16'd1, 0});
        tbl.push_back('{2'b01, 48'h2000, 2'b00, 2'b00, 3'b000, 0, 16'd0, 3'b000, 1, 16'd1, 0});
        tbl.push_back('{2'b00, 48'h0,    2'b01, 2'b01, 3'b000, 0, 16'd0, 3'b000, 1, 16'd1, 0});
        tbl.push_back('{2'b01, 48'h1008, 2'b00, 2'b00, 3'b000, 0, 16'd0, 3'b000, 0, 16'd1, 0});
        tbl.push_back('{2'b00, 48'h0,    2'b01, 2'b01, 3'b000, 0, 16'd0, 3'b010, 0, 16'd2, 0});
        tbl.push_back('{2'b01, 48'h1010, 2'b00, 2'b00, 3'b000, 0, 16'd0, 3'b000, 0, 16'd2, 0});
        tbl.push_back('{2'b00, 48'h0,    2'b01, 2'b01, 3'b000, 0, 16'd0, 3'b000, 0, 16'd2, 0});
        tbl.push_back('{2'b00, 48'h0,    2'b00, 2'b00, 3'b000, 1, 16'd0, 3'b000, 1, 16'd0, 0});
        tbl.push_back('{2'b01, 48'h1ABC, 2'b00, 2'b00, 3'b000, 0, 16'd0, 3'b000, 1, 16'd0, 0});
        tbl.push_back('{2'b10, 48'h5000, 2'b00, 2'b00, 3'b000, 0, 16'd0, 3'b000, 1, 16'd0, 0});
        tbl.push_back('{2'b00, 48'h0,    2'b10, 2'b10, 3'b001, 0, 16'd0, 3'b001, 1, 16'd0, 0});
        tbl.push_back('{2'b00, 48'h0,    2'b01, 2'b01, 3'b001, 0, 16'd0, 3'b010, 1, 16'd1, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(0, tbl[i].req, tbl[i].addr, tbl[i].rsp, tbl[i].last, tbl[i].err,
                  tbl[i].arm, 0, tbl[i].count);
            check($sformatf("tbl%0d_err", i), 48'(got_err), 48'(tbl[i].e_err));
            check($sformatf("tbl%0d_armed", i), 48'(armed_o), 48'(tbl[i].e_armed));
            check($sformatf("tbl%0d_inj_count", i), 48'(inj_count_o), 48'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_desync", i), 48'(desync_o), 48'(tbl[i].e_desync));
        end

        // Unlimited budget: 20 matching requests with 4-beat bursts.
        arm(16'd0);
        for (int i = 0; i < 20; i++) begin
            req(0, 48'h1000 + 48'(i * 4));
            for (int b = 0; b < 4; b++) begin
                beat(0, b == 3, 3'b100);
                check($sformatf("unlim_req%0d_beat%0d", i, b), 48'(got_err), 48'(Code));
            end
        end
        check("unlim_armed", 48'(armed_o), 48'h1);
        check("unlim_inj_count", 48'(inj_count_o), 48'd20);

        // Disarm with three tagged requests in flight.
        arm(16'd0);
        for (int i = 0; i < 3; i++) req(0, 48'h1100);
        drive(0, '0, '0, '0, '0, '0, 0, 1, '0);
        check("disarm_armed", 48'(armed_o), 48'h0);
        for (int i = 0; i < 3; i++) begin
            beat(0, 1, 3'b000);
            check($sformatf("disarm_inflight%0d", i), 48'(got_err), 48'(Code));
        end
        req(0, 48'h1200);
        beat(0, 1, 3'b011);
        check("disarm_next_clean", 48'(got_err), 48'h3);
        check("disarm_inj_count", 48'(inj_count_o), 48'd3);

        // Overflow on the fifth outstanding request, then re-arm and drain.
        arm(16'd0);
        for (int i = 0; i < 4; i++) req(0, 48'h1300);
        check("ovf_desync_before", 48'(desync_o), 48'h0);
        check("ovf_armed_before", 48'(armed_o), 48'h1);
        req(0, 48'h1300);
        check("ovf_desync", 48'(desync_o), 48'h1);
        check("ovf_armed", 48'(armed_o), 48'h0);
        arm(16'd0);
        check("ovf_rearm_desync", 48'(desync_o), 48'h0);
        check("ovf_rearm_armed", 48'(armed_o), 48'h1);
        for (int i = 0; i < 4; i++) begin
            beat(0, 1, 3'b000);
            check($sformatf("ovf_drain%0d", i), 48'(got_err), 48'(Code));
        end
        check("ovf_drain_desync", 48'(desync_o), 48'h0);

        // Reset in the middle of a 4-beat burst.
        arm(16'd0);
        req(0, 48'h1400);
        beat(0, 0, 3'b001);
        check("rstmid_beat1", 48'(got_err), 48'(Code));
        beat(0, 0, 3'b001);
        check("rstmid_beat2", 48'(got_err), 48'(Code));
        drive(1, '0, '0, '0, '0, '0, 0, 0, '0);
        beat(0, 0, 3'b001);
        check("rstmid_beat3", 48'(got_err), 48'h1);
        check("rstmid_desync_b3", 48'(desync_o), 48'h0);
        beat(0, 1, 3'b001);
        check("rstmid_beat4", 48'(got_err), 48'h1);
        check("rstmid_desync", 48'(desync_o), 48'h1);
        check("rstmid_armed", 48'(armed_o), 48'h0);
        check("rstmid_inj_count", 48'(inj_count_o), 48'h0);

        // Randomized traffic against the reference model.
        prev_arm = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) cfg_addr_mask_i = '0;
            else if ($urandom_range(0, 49) == 0) cfg_addr_mask_i = Mask;
            if ($urandom_range(0, 99) == 0) cfg_err_code_i = EB'($urandom);

            r_arm = !prev_arm && ($urandom_range(0, 39) == 0);
            r_dis = ($urandom_range(0, 79) == 0);
            rch = $urandom_range(0, 9);
            r_req = (rch < 3) ? 2'b01 : (rch < 5) ? 2'b10 : 2'b00;
            if ($urandom_range(0, 1) == 0) r_addr = Base | 48'($urandom_range(0, 4095));
            else r_addr = {16'($urandom), 32'($urandom)};

            r_rsp = '0;
            r_last = '0;
            pch = $urandom_range(0, 1);
            if ($urandom_range(0, 9) < 5) begin
                if (qsize(pch) > 0 || (!r_req[pch] && $urandom_range(0, 29) == 0)) begin
                    r_rsp  = NC'(1 << pch);
                    r_last = ($urandom_range(0, 1) == 0) ? r_rsp : '0;
                end
            end

            drive(($urandom_range(0, 599) == 0), r_req, r_addr, r_rsp, r_last, EB'($urandom),
                  r_arm, r_dis, 16'($urandom_range(0, 4)));
            prev_arm = r_arm;
            check($sformatf("rnd%0d_err", n), 48'(got_err), 48'(exp_err));
            check($sformatf("rnd%0d_armed", n), 48'(armed_o), 48'(m_armed));
            check($sformatf("rnd%0d_inj_count", n), 48'(inj_count_o), 48'(m_cnt));
            check($sformatf("rnd%0d_desync", n), 48'(desync_o), 48'(m_desync));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
